// File: rtl/mat_mult_seq_pkg.sv
// Shared definitions for the 5x5 signed 8-bit matrix-multiply sequencer.
//
// Matrices are packed row-major with element (0,0) in the most significant
// byte, so element (r,c) occupies bits [elem_lsb(r,c) +: DW].
package mat_mult_seq_pkg;

    localparam int DW    = 8;          // element width, fixed by the inner-product unit
    localparam int N     = 5;          // matrix dimension, fixed by the inner-product unit
    localparam int MAT_W = N * N * DW; // packed matrix width (200)
    localparam int VEC_W = N * DW;     // packed row/column vector width (40)
    localparam int IDX_W = 5;          // linear element index width, covers 0..24

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of the least significant bit of element (r,c).
    function automatic int elem_lsb(input int r, input int c);
        return DW * (N * N - 1 - (N * r + c));
    endfunction

endpackage

// File: rtl/mat_mult_seq_vec_sel.sv
// mat_vec_sel: combinational operand selector for the matrix-multiply sequencer.
//
// Decodes the linear element index idx = 5r + c and presents row r of A and
// column c of B to the inner-product unit. Element 0 of each vector sits in
// the most significant byte.
//
// Ports:
//   mat_a  in   MAT_W  registered matrix A
//   mat_b  in   MAT_W  registered matrix B
//   idx    in   IDX_W  linear element index, 0..24
//   lin    out  VEC_W  row r of A, A[r][0] at [39:32]
//   col    out  VEC_W  column c of B, B[0][c] at [39:32]
module mat_vec_sel
    import mat_mult_seq_pkg::*;
(
    input  logic [MAT_W-1:0] mat_a,
    input  logic [MAT_W-1:0] mat_b,
    input  logic [IDX_W-1:0] idx,
    output logic [VEC_W-1:0] lin,
    output logic [VEC_W-1:0] col
);

    // Rather than dividing idx by 5, compare against every (r,c) pair; all
    // slice offsets are then constants and the logic is a flat mux.
    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise the
        // out-of-range idx values (25..31) would infer latches.
        lin = '0;
        col = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (idx == IDX_W'(N * r + c)) begin
                    for (int k = 0; k < N; k++) begin
                        lin[(N - 1 - k) * DW +: DW] = mat_a[elem_lsb(r, k) +: DW];
                        col[(N - 1 - k) * DW +: DW] = mat_b[elem_lsb(k, c) +: DW];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mat_mult_seq.sv
// mat_mult_seq: sequencer and result collector for the 5x5 signed 8-bit
// matrix multiply.
//
// On an accepted start the operand matrices are captured, then the 25
// (row, column) pairs are walked one per cycle. Each cycle the selected row
// of A and column of B go to the external combinational inner-product unit,
// whose 8-bit result and overflow flag are stored into C.
//
// Ports:
//   clk      in   1      clock
//   rst      in   1      synchronous active-high reset
//   start    in   1      one-cycle request, only honoured in IDLE
//   mat_a    in   200    matrix A, element (r,c) at [199-8*(5r+c) -: 8]
//   mat_b    in   200    matrix B, same packing
//   lin      out  40     row r of A to the inner-product unit
//   col      out  40     column c of B to the inner-product unit
//   n_in     in   8      signed inner product from the unit (same cycle)
//   ovf_in   in   1      overflow flag from the unit
//   mat_c    out  200    result matrix, same packing as mat_a
//   ovf      out  1      sticky overflow over the current operation
//   ovf_idx  out  5      linear index of the first overflowing element
//   busy     out  1      high while walking the elements
//   done     out  1      one-cycle pulse when mat_c is complete
module mat_mult_seq
    import mat_mult_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MAT_W-1:0] mat_a,
    input  logic [MAT_W-1:0] mat_b,
    output logic [VEC_W-1:0] lin,
    output logic [VEC_W-1:0] col,
    input  logic [DW-1:0]    n_in,
    input  logic             ovf_in,
    output logic [MAT_W-1:0] mat_c,
    output logic             ovf,
    output logic [IDX_W-1:0] ovf_idx,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [MAT_W-1:0] a_reg;
    logic [MAT_W-1:0] b_reg;
    logic [VEC_W-1:0] sel_lin;
    logic [VEC_W-1:0] sel_col;
    logic             accept;
    logic             last;

    assign accept = (state == IDLE) && start;
    assign last   = (idx == IDX_W'(N * N - 1));

    // ------------------------------------------------------------------
    // Next-state and status decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter and result collector
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            mat_c   <= '0;
            ovf     <= 1'b0;
            ovf_idx <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        mat_c   <= '0;
                        ovf     <= 1'b0;
                        ovf_idx <= '0;
                    end
                end
                RUN: begin
                    // Stored verbatim: on overflow only the low 8 bits survive.
                    for (int k = 0; k < N * N; k++) begin
                        if (idx == IDX_W'(k)) begin
                            mat_c[DW * (N * N - 1 - k) +: DW] <= n_in;
                        end
                    end
                    // Only the first overflow of an operation is located.
                    if (ovf_in && !ovf) begin
                        ovf_idx <= idx;
                    end
                    ovf <= ovf | ovf_in;
                    idx <= last ? '0 : idx + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand copies
    // ------------------------------------------------------------------
    // NOTE: the operand copies are plain data storage with no reset; they are
    // only read during RUN, which is always preceded by a load.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            a_reg <= mat_a;
            b_reg <= mat_b;
        end
    end

    mat_vec_sel u_sel (
        .mat_a (a_reg),
        .mat_b (b_reg),
        .idx   (idx),
        .lin   (sel_lin),
        .col   (sel_col)
    );

    // The inner-product unit sees zeros whenever no element is being computed.
    assign lin = (state == RUN) ? sel_lin : '0;
    assign col = (state == RUN) ? sel_col : '0;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq. A behavioural inner-product unit
// closes the loop from lin/col back to n_in/ovf_in.
module tb_mat_mult_seq;
    import mat_mult_seq_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [MAT_W-1:0] mat_a;
    logic [MAT_W-1:0] mat_b;
    logic [VEC_W-1:0] lin;
    logic [VEC_W-1:0] col;
    logic [DW-1:0]    n_in;
    logic             ovf_in;
    logic [MAT_W-1:0] mat_c;
    logic             ovf;
    logic [IDX_W-1:0] ovf_idx;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mat_mult_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mat_a   (mat_a),
        .mat_b   (mat_b),
        .lin     (lin),
        .col     (col),
        .n_in    (n_in),
        .ovf_in  (ovf_in),
        .mat_c   (mat_c),
        .ovf     (ovf),
        .ovf_idx (ovf_idx),
        .busy    (busy),
        .done    (done)
    );

    // Inner-product unit: signed dot product, low byte out, overflow when the
    // exact sum leaves the signed 8-bit range.
    int s;
    always_comb begin
        s = 0;
        for (int k = 0; k < N; k++) begin
            s += $signed(lin[VEC_W - 1 - DW * k -: DW]) * $signed(col[VEC_W - 1 - DW * k -: DW]);
        end
        n_in   = s[7:0];
        ovf_in = (s > 127) || (s < -128);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [MAT_W-1:0] fill(input logic [7:0] v);
        logic [MAT_W-1:0] m;
        for (int i = 0; i < N * N; i++) m[MAT_W - 1 - DW * i -: DW] = v;
        return m;
    endfunction

    function automatic logic [MAT_W-1:0] ident();
        logic [MAT_W-1:0] m;
        m = '0;
        for (int r = 0; r < N; r++) m[MAT_W - 1 - DW * (6 * r) -: DW] = 8'd1;
        return m;
    endfunction

    function automatic logic [MAT_W-1:0] seq_1_25();
        logic [MAT_W-1:0] m;
        for (int i = 0; i < N * N; i++) m[MAT_W - 1 - DW * i -: DW] = 8'(i + 1);
        return m;
    endfunction

    // Pulse start with the given operands, then follow the run. done_at is the
    // number of cycles after the first RUN cycle at which done was seen
    // (-1 if never within the budget). Ends sampling inside the DONE cycle.
    task automatic run_op(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b,
                          input bit scramble, output int busy_cnt, output int done_at);
        @(posedge clk); #1;
        mat_a = a;
        mat_b = b;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        busy_cnt = 0;
        done_at  = -1;
        for (int n = 0; n < 60 && done_at < 0; n++) begin
            if (scramble && n == 1) begin
                mat_a = ~a;
                mat_b = ~b;
            end
            if (busy) busy_cnt++;
            if (done) done_at = n;
            if (done_at < 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        mat_a = fill(8'h33);
        mat_b = fill(8'h44);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (mat_c !== '0) begin n_fail++; $display("FAIL reset_mat_c: got %h want 0", mat_c); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_checks++; if (ovf_idx !== 5'd0) begin n_fail++; $display("FAIL reset_ovf_idx: got %0d want 0", ovf_idx); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        n_checks++; if (lin !== '0 || col !== '0) begin n_fail++; $display("FAIL reset_lin_col: got %h %h want 0 0", lin, col); end
        rst = 1'b0;
    endtask

    task automatic test_identity();
        int bc, da;
        run_op(ident(), seq_1_25(), 1'b0, bc, da);
        n_checks++; if (da !== 25) begin n_fail++; $display("FAIL ident_done_latency: got %0d want 25", da); end
        n_checks++; if (bc !== 25) begin n_fail++; $display("FAIL ident_busy_cycles: got %0d want 25", bc); end
        n_checks++; if (mat_c !== seq_1_25()) begin n_fail++; $display("FAIL ident_mat_c: got %h want %h", mat_c, seq_1_25()); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ident_ovf: got %b want 0", ovf); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ident_after_done: got busy=%b done=%b want 0 0", busy, done); end
        n_checks++; if (mat_c !== seq_1_25()) begin n_fail++; $display("FAIL ident_hold: got %h want %h", mat_c, seq_1_25()); end
        n_checks++; if (lin !== '0 || col !== '0) begin n_fail++; $display("FAIL ident_idle_lin_col: got %h %h want 0 0", lin, col); end
    endtask

    // Operands are scrambled one cycle after start; the result must not care.
    task automatic test_all_two();
        int bc, da;
        run_op(fill(8'd2), fill(8'd2), 1'b1, bc, da);
        n_checks++; if (da !== 25) begin n_fail++; $display("FAIL two_done_latency: got %0d want 25", da); end
        n_checks++; if (mat_c !== fill(8'h14)) begin n_fail++; $display("FAIL two_mat_c: got %h want %h", mat_c, fill(8'h14)); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL two_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_negative();
        int bc, da;
        run_op(fill(8'hFF), fill(8'h01), 1'b0, bc, da);
        n_checks++; if (mat_c !== fill(8'hFB)) begin n_fail++; $display("FAIL neg_mat_c: got %h want %h", mat_c, fill(8'hFB)); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL neg_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_ovf_first();
        int bc, da;
        run_op(fill(8'd6), fill(8'd6), 1'b0, bc, da);
        n_checks++; if (mat_c !== fill(8'hB4)) begin n_fail++; $display("FAIL ovf0_mat_c: got %h want %h", mat_c, fill(8'hB4)); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf0_ovf: got %b want 1", ovf); end
        n_checks++; if (ovf_idx !== 5'd0) begin n_fail++; $display("FAIL ovf0_idx: got %0d want 0", ovf_idx); end
    endtask

    task automatic test_ovf_last();
        int bc, da;
        logic [MAT_W-1:0] a;
        a = '0;
        a[7:0] = 8'd16;
        run_op(a, a, 1'b0, bc, da);
        n_checks++; if (mat_c !== '0) begin n_fail++; $display("FAIL ovf24_mat_c: got %h want 0", mat_c); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf24_ovf: got %b want 1", ovf); end
        n_checks++; if (ovf_idx !== 5'd24) begin n_fail++; $display("FAIL ovf24_idx: got %0d want 24", ovf_idx); end
    endtask

    // start during DONE is dropped; the next start from IDLE runs normally.
    task automatic test_back_to_back();
        int bc, da;
        run_op(fill(8'd1), fill(8'd1), 1'b0, bc, da);
        n_checks++; if (mat_c !== fill(8'h05)) begin n_fail++; $display("FAIL b2b_first_mat_c: got %h want %h", mat_c, fill(8'h05)); end
        mat_a = fill(8'd2);
        mat_b = fill(8'd2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done: got busy=%b want 0", busy); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || mat_c !== fill(8'h05)) begin n_fail++; $display("FAIL b2b_still_idle: got busy=%b mat_c=%h", busy, mat_c); end
        run_op(fill(8'd2), fill(8'd2), 1'b0, bc, da);
        n_checks++; if (da !== 25 || mat_c !== fill(8'h14)) begin n_fail++; $display("FAIL b2b_second: got done_at=%0d mat_c=%h want 25 %h", da, mat_c, fill(8'h14)); end
    endtask

    // start re-pulsed at RUN cycles 3 and 10, reset at RUN cycle 12.
    task automatic test_abort();
        int bc, da;
        @(posedge clk); #1;
        mat_a = ident();
        mat_b = seq_1_25();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (n == 10) begin
                n_checks++; if (col !== 40'h01060B1015 || lin !== 40'h0000010000) begin n_fail++; $display("FAIL abort_idx10_vectors: got %h %h want 0000010000 01060b1015", lin, col); end
            end
            if (n == 11) begin
                n_checks++; if (busy !== 1'b1 || mat_c[MAT_W-1 -: DW] !== 8'd1) begin n_fail++; $display("FAIL abort_partial: got busy=%b c00=%h want 1 01", busy, mat_c[MAT_W-1 -: DW]); end
            end
            start = (n == 2 || n == 9);
            rst   = (n == 11);
            @(posedge clk); #1;
        end
        rst   = 1'b0;
        start = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got busy=%b done=%b want 0 0", busy, done); end
        n_checks++; if (mat_c !== '0 || ovf !== 1'b0) begin n_fail++; $display("FAIL abort_cleared: got mat_c=%h ovf=%b want 0 0", mat_c, ovf); end
        run_op(ident(), seq_1_25(), 1'b0, bc, da);
        n_checks++; if (da !== 25 || bc !== 25) begin n_fail++; $display("FAIL abort_rerun_timing: got done_at=%0d busy=%0d want 25 25", da, bc); end
        n_checks++; if (mat_c !== seq_1_25()) begin n_fail++; $display("FAIL abort_rerun_mat_c: got %h want %h", mat_c, seq_1_25()); end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_two();
        test_negative();
        test_ovf_first();
        test_ovf_last();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
